// File: rtl/divisor_secuencial_4bits.sv
// Sequential unsigned restoring divider.
// Produces one quotient bit per clock behind an Inicio/Listo handshake, and
// flags division by zero with Error_Div0 (quotient all ones, remainder = X).
module divisor_secuencial_4bits #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         Inicio,
    input  logic [N-1:0] X,
    input  logic [N-1:0] Y,
    output logic [N-1:0] Cociente,
    output logic [N-1:0] Residuo,
    output logic         Ocupado,
    output logic         Listo,
    output logic         Error_Div0
);

    // Step counter only needs to reach N-1; keep at least one bit for N == 1.
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] ULTIMO_PASO = CW'(N - 1);

    typedef enum logic [1:0] {
        REPOSO  = 2'd0,
        CALCULO = 2'd1,
        FIN     = 2'd2
    } estado_t;

    estado_t         estado_q;
    logic [N-1:0]    q_q;        // dividend shifting out / quotient shifting in
    logic [N-1:0]    d_q;        // latched divisor
    logic [N:0]      r_q;        // partial remainder, one guard bit wide
    logic [CW-1:0]   cnt_q;
    logic [N-1:0]    cociente_q;
    logic [N-1:0]    residuo_q;
    logic            ocupado_q;
    logic            listo_q;
    logic            error_q;

    logic [N:0]      r_shift_d;
    logic [N:0]      r_d;
    logic [N-1:0]    q_d;

    // One restoring step: shift {R,Q} left, then subtract D when it fits.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        r_shift_d = {r_q[N-1:0], q_q[N-1]};
        r_d       = r_shift_d;
        q_d       = q_q << 1;
        if (r_shift_d >= {1'b0, d_q}) begin
            r_d    = r_shift_d - {1'b0, d_q};
            q_d[0] = 1'b1;
        end
    end

    // Control FSM and datapath registers; all outputs are registered here.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register sees the pre-edge values of the others.
        if (rst) begin
            estado_q   <= REPOSO;
            q_q        <= '0;
            d_q        <= '0;
            r_q        <= '0;
            cnt_q      <= '0;
            cociente_q <= '0;
            residuo_q  <= '0;
            ocupado_q  <= 1'b0;
            listo_q    <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            listo_q <= 1'b0;
            unique case (estado_q)
                REPOSO: begin
                    if (Inicio) begin
                        q_q       <= X;
                        d_q       <= Y;
                        r_q       <= '0;
                        cnt_q     <= '0;
                        error_q   <= 1'b0;
                        ocupado_q <= 1'b1;
                        estado_q  <= (Y == '0) ? FIN : CALCULO;
                    end
                end

                CALCULO: begin
                    q_q   <= q_d;
                    r_q   <= r_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == ULTIMO_PASO) begin
                        cociente_q <= q_d;
                        residuo_q  <= r_d[N-1:0];
                        listo_q    <= 1'b1;
                        ocupado_q  <= 1'b0;
                        estado_q   <= REPOSO;
                    end
                end

                FIN: begin
                    // Q still holds the untouched dividend here.
                    cociente_q <= '1;
                    residuo_q  <= q_q;
                    error_q    <= 1'b1;
                    listo_q    <= 1'b1;
                    ocupado_q  <= 1'b0;
                    estado_q   <= REPOSO;
                end

                default: begin
                    ocupado_q <= 1'b0;
                    estado_q  <= REPOSO;
                end
            endcase
        end
    end

    assign Cociente   = cociente_q;
    assign Residuo    = residuo_q;
    assign Ocupado    = ocupado_q;
    assign Listo      = listo_q;
    assign Error_Div0 = error_q;

endmodule
